// File: rtl/pc_dbg_pkg.sv
// Shared encodings for the fetch-stage program counter and its debug FSM.
package pc_dbg_pkg;

  localparam int unsigned StateW = 2;

  // 2'b11 is unused and decodes to halted behaviour.
  typedef enum logic [StateW-1:0] {
    PC_RUN    = 2'b00,
    PC_STEP   = 2'b01,
    PC_HALTED = 2'b10
  } pc_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with enable and synchronous clear, updated on the falling edge.
module sat_counter #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && (cnt_q != '1)) begin
      cnt_d = cnt_q + WIDTH'(1);
    end
  end

  always_ff @(negedge clk) begin
    cnt_q <= cnt_d;
  end

  assign count = cnt_q;

endmodule

// File: rtl/pc_debug_ctrl.sv
// Fetch program counter with run / single-step / halted debug control, one breakpoint
// and a saturating retired-fetch counter. All state updates on the falling edge.
module pc_debug_ctrl
  import pc_dbg_pkg::*;
#(
  parameter int unsigned    ADDR_W     = 8,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0,
  parameter int unsigned    INCR       = 1,
  parameter int unsigned    CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              dbg_reset,
  input  logic              stall,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_addr,
  input  logic              halt_instr,
  input  logic              dbg_mode,
  input  logic              dbg_step,
  input  logic              dbg_resume,
  input  logic              bp_en,
  input  logic [ADDR_W-1:0] bp_addr,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_next,
  output logic              advance,
  output logic              halted,
  output logic [1:0]        state,
  output logic [CNT_W-1:0]  fetch_cnt
);

  logic              rst;
  logic [ADDR_W-1:0] pc_q;
  pc_state_e         state_q, state_d;
  logic              step_pend_q, step_pend_d;
  logic              bp_skip_q, bp_skip_d;
  logic              bp_hit;
  logic              stop;

  assign rst     = reset | dbg_reset;
  assign pc_next = redirect_valid ? redirect_addr : pc_q + ADDR_W'(INCR);
  assign bp_hit  = bp_en && (pc_q == bp_addr) && !bp_skip_q;
  assign stop    = halt_instr | bp_hit;

  always_ff @(negedge clk) begin
    if (rst) begin
      pc_q        <= RESET_ADDR;
      state_q     <= PC_RUN;
      step_pend_q <= 1'b0;
      bp_skip_q   <= 1'b0;
    end else begin
      if (advance) pc_q <= pc_next;
      state_q     <= state_d;
      step_pend_q <= step_pend_d;
      bp_skip_q   <= bp_skip_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      PC_RUN: begin
        if (stop)          state_d = PC_HALTED;
        else if (dbg_mode) state_d = PC_STEP;
      end
      PC_STEP: begin
        if (stop)           state_d = PC_HALTED;
        else if (!dbg_mode) state_d = PC_RUN;
      end
      default: begin
        if (dbg_resume) state_d = dbg_mode ? PC_STEP : PC_RUN;
      end
    endcase
  end

  always_comb begin
    advance     = 1'b0;
    step_pend_d = step_pend_q;
    bp_skip_d   = bp_skip_q;
    case (state_q)
      PC_RUN: begin
        if (!stop && !dbg_mode) advance = ~stall;
      end
      PC_STEP: begin
        if (stop || !dbg_mode) begin
          step_pend_d = 1'b0;
        end else begin
          advance = (dbg_step | step_pend_q) & ~stall;
          // A step requested during a stall is remembered; further requests are dropped.
          if (advance)       step_pend_d = 1'b0;
          else if (dbg_step) step_pend_d = 1'b1;
        end
      end
      default: begin
        step_pend_d = 1'b0;
        if (dbg_resume) bp_skip_d = 1'b1;
      end
    endcase
    if (advance) bp_skip_d = 1'b0;
  end

  assign pc     = pc_q;
  assign state  = state_q;
  assign halted = (state_q != PC_RUN) && (state_q != PC_STEP);

  sat_counter #(
    .WIDTH(CNT_W)
  ) u_fetch_cnt (
    .clk  (clk),
    .clr  (rst),
    .en   (advance),
    .count(fetch_cnt)
  );

endmodule
